pipeline_hazard_controller: RTL

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 113 +++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush control for a 5-stage pipeline with data-memory wait timeout.
// Optional performance counters enabled by defining PIPE_PERF_CNT_EN.
module pipeline_hazard_controller #(
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_mem_read_i,
  input  logic        branch_taken_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ready_i,
  input  logic        imem_ready_i,
  output logic        pc_en_o,
  output logic        if_id_en_o,
  output logic        if_id_flush_o,
  output logic        id_ex_en_o,
  output logic        id_ex_flush_o,
  output logic        ex_mem_en_o,
  output logic        mem_wb_en_o,
  output logic        mem_wb_flush_o,
  output logic        fault_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o
);
  typedef enum logic [1:0] {RUN = 2'b00, DWAIT = 2'b01, BAD = 2'b10, FAULT = 2'b11} state_t;
  state_t state, state_nx;
  logic [7:0] wait_cnt, wait_cnt_nx;
  logic load_use, dstall, br_flush;
  assign load_use = ex_mem_read_i & (ex_rd_i != 5'd0) & ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));
  assign dstall   = ~dmem_ready_i & ((state == RUN & dmem_req_i) | state == DWAIT);
  assign br_flush = branch_taken_i & ~dstall & (state == RUN | state == DWAIT);
  assign state_o  = state;
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    case (state)
      RUN: if (dstall) begin
        state_nx    = DWAIT;
        wait_cnt_nx = 8'd1;
      end
      DWAIT: if (dmem_ready_i) begin
        state_nx    = RUN;
        wait_cnt_nx = 8'd0;
      end else if (wait_cnt == TIMEOUT) state_nx = FAULT;
      else wait_cnt_nx = wait_cnt + 8'd1;
      FAULT:   state_nx = FAULT;
      default: state_nx = RUN;
    endcase
  end
  // priority chain: reset, fault, illegal state, memory wait, branch, load-use, fetch miss
  always_comb begin
    pc_en_o        = 1'b1;
    if_id_en_o     = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_en_o     = 1'b1;
    id_ex_flush_o  = 1'b0;
    ex_mem_en_o    = 1'b1;
    mem_wb_en_o    = 1'b1;
    mem_wb_flush_o = 1'b0;
    fault_o        = 1'b0;
    if (!reset_i) begin
      {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o} = 5'b0;
      {if_id_flush_o, id_ex_flush_o, mem_wb_flush_o} = 3'b111;
    end else if (state == FAULT) begin
      {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o} = 5'b0;
      mem_wb_flush_o = 1'b1;
      fault_o        = 1'b1;
    end else if (state == BAD) begin
      {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o} = 5'b0;
    end else if (dstall) begin
      {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o} = 4'b0;
      mem_wb_flush_o = 1'b1;
    end else if (br_flush) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (load_use) begin
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      id_ex_flush_o = 1'b1;
    end else if (!imem_ready_i) begin
      pc_en_o       = 1'b0;
      if_id_flush_o = 1'b1;
    end
  end
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (!pc_en_o && state != FAULT) stall_q <= stall_q + 32'd1;
      if (br_flush) flush_q <= flush_q + 32'd1;
    end
  assign stall_cycles_o = stall_q;
  assign flush_count_o  = flush_q;
`else
  assign stall_cycles_o = 32'd0;
  assign flush_count_o  = 32'd0;
`endif
endmodule
